multicycle_mips: RTL and testbench
==================================

# multicycle_mips

Multi-cycle MIPS core: the next generation of the team's single-cycle processor, trading one-instruction-per-cycle for a five-state FSM that reuses one ALU and tolerates data memory wait states through a ready handshake. Data memory address width and reset PC are parameters. It sits between the instruction ROM and the data SRAM with the same SRAM-style control pins (CEN/WEN/OEN) as the single-cycle core.

## Interface
- DMEM_AW, 7, data memory word-address width; `A` = ALUOut[DMEM_AW+1:2]
- RESET_PC, 32'h0, PC value after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IR_addr  out  32  instruction address (= PC)
- IR  in  32  instruction word, valid while in IF
- RF_writedata  out  32  data being written to the register file this cycle
- rf_we  out  1  register-file write strobe
- ReadDataMem  in  32  data memory read data
- mem_ready  in  1  data memory access completes this cycle
- CEN  out  1  chip enable, active low
- WEN  out  1  write enable, active low (0 = write, 1 = read)
- OEN  out  1  output enable, active low; tied 0
- A  out  DMEM_AW  data memory word address
- ReadData2  out  32  store data (rt register value)
- fsm_state  out  3  current state encoding
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4.
- IF: IR latched into instruction register; PC <= PC+4 at end of cycle; -> ID.
- ID: rs/rt read into A/B registers; ALUOut <= PC + (sext(imm)<<2) (branch target); -> EX.
- EX per opcode:
  - R-type (add, sub, and, or, nor, slt): ALUOut <= A op B; -> WB.
  - addi (001000): ALUOut <= A + sext(imm); -> WB.
  - lw/sw: ALUOut <= A + sext(imm); -> MEM.
  - beq/bne: if (A==B) / (A!=B) then PC <= ALUOut; -> IF; instr_done.
  - j: PC <= {PC[31:28], addr26, 2'b00}; -> IF; instr_done.
  - jal: as j, plus $31 <= PC (already PC+4) this cycle; -> IF; instr_done.
  - jr (R-type funct 001000): PC <= A; no RF write; -> IF; instr_done.
  - Unknown opcode/funct: no state change; -> IF; instr_done (NOP).
- MEM: CEN=0; WEN=0 for sw, 1 for lw. Hold MEM while mem_ready=0. On mem_ready=1: sw -> IF with instr_done; lw captures ReadDataMem into MDR -> WB.
- WB: rf_we=1; dest rd (R-type) or rt (addi, lw); data ALUOut or MDR; -> IF; instr_done.
- slt is signed compare. Adds wrap modulo 2^32; no overflow trap.
- $0 hardwired to zero: writes discarded, reads return 0.

## Timing
- Latency: beq/bne/j/jal/jr/NOP = 3 cycles; R-type/addi/sw = 4; lw = 5; each cycle of mem_ready=0 in MEM adds one.
- Reset (async, rst_n=0): PC=RESET_PC, state=IF, all 32 registers=0, IR/A/B/ALUOut/MDR=0; outputs CEN=1, WEN=1, OEN=0, rf_we=0, instr_done=0, fsm_state=0, IR_addr=RESET_PC.
- Reset mid-instruction (including in MEM waiting on mem_ready): instruction abandoned, no RF/PC update, CEN deasserts immediately.
- CEN=1 and WEN=1 in every state except MEM; A and ReadData2 stable throughout MEM including waits.
- RF_writedata/rf_we combinational in WB (and EX for jal, value = PC); register written at the rising edge ending that cycle; new value readable in the following instruction's ID.
- instr_done asserted in the final state cycle only; next cycle fsm_state=IF.
- Branch target uses PC+4 of the branch instruction; branch to self (imm = -1) loops indefinitely.

## Test plan
- Reset: hold rst_n=0 with RESET_PC=32'h100 -> IR_addr=32'h100, CEN=1, WEN=1, fsm_state=0; release -> first fetch at 32'h100.
- ALU: addi $1,$0,5; addi $2,$0,-3; slt $3,$2,$1; nor $4,$1,$2 -> RF_writedata 5, 32'hFFFFFFFD, 1, 32'h00000002; each 4 cycles.
- Memory with waits: sw $1,8($0) with mem_ready low 2 cycles -> A=2, WEN=0, ReadData2=5 held 3 cycles; then lw $5,8($0) with model returning 5 -> $5=5, lw takes 5 cycles.
- Control flow: beq $1,$1,+2 -> PC = branch PC+12 in 3 cycles; bne $1,$1,+2 -> PC+4; jal 0x40 at PC 0x10 -> $31=0x14, PC=0x100; jr $31 -> PC=0x14.
- $0 protection: addi $0,$0,7 then add $6,$0,$0 -> $6=0.
- Async reset while in MEM awaiting mem_ready -> CEN=1 same cycle, no register written, PC=RESET_PC.

Source files
------------

// File: rtl/multicycle_mips_if.sv
// Instruction-ROM and data-SRAM bus of the multi-cycle MIPS core.
// The core drives it through the master modport; memories sit on the slave side.
interface multicycle_mips_if #(parameter int DMEM_AW = 7);
  logic [31:0]        IR_addr;
  logic [31:0]        IR;
  logic [31:0]        ReadDataMem;
  logic               mem_ready;
  logic               CEN;
  logic               WEN;
  logic               OEN;
  logic [DMEM_AW-1:0] A;
  logic [31:0]        ReadData2;

  modport master (output IR_addr, CEN, WEN, OEN, A, ReadData2,
                  input  IR, ReadDataMem, mem_ready);
  modport slave  (input  IR_addr, CEN, WEN, OEN, A, ReadData2,
                  output IR, ReadDataMem, mem_ready);
endinterface

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core: IF/ID/EX/MEM/WB FSM sharing one ALU, with a
// ready-handshaked data memory stage that stretches for SRAM wait states.
module multicycle_mips #(
  parameter int          DMEM_AW  = 7,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_mips_if.master   bus,
  output logic [31:0]         RF_writedata,
  output logic                rf_we,
  output logic [2:0]          fsm_state,
  output logic                instr_done
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr;
  logic [31:0] r_rf [32];
  logic        r_cen, r_wen;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_waddr;
  logic [31:0] w_simm, w_alu_r;
  logic        w_rtype, w_ralu, w_jr, w_addi, w_lw, w_sw, w_beq, w_bne, w_j, w_jal;
  logic        w_unused_shamt;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];
  assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_unused_shamt = ^r_ir[10:6];

  assign w_rtype = (w_op == 6'h00);
  assign w_ralu  = w_rtype && (w_funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A});
  assign w_jr    = w_rtype && (w_funct == 6'h08);
  assign w_addi  = (w_op == 6'h08);
  assign w_lw    = (w_op == 6'h23);
  assign w_sw    = (w_op == 6'h2B);
  assign w_beq   = (w_op == 6'h04);
  assign w_bne   = (w_op == 6'h05);
  assign w_j     = (w_op == 6'h02);
  assign w_jal   = (w_op == 6'h03);

  always_comb begin
    w_alu_r = '0;
    case (w_funct)
      6'h20: w_alu_r = r_a + r_b;
      6'h22: w_alu_r = r_a - r_b;
      6'h24: w_alu_r = r_a & r_b;
      6'h25: w_alu_r = r_a | r_b;
      6'h27: w_alu_r = ~(r_a | r_b);
      6'h2A: w_alu_r = {31'd0, $signed(r_a) < $signed(r_b)};
      default: w_alu_r = '0;
    endcase
  end

  // Write port and completion strobe depend on decoded opcode and mem_ready,
  // so they are combinational off the state register.
  always_comb begin
    rf_we        = 1'b0;
    w_waddr      = '0;
    RF_writedata = '0;
    instr_done   = 1'b0;
    case (r_state)
      S_EX: begin
        if (w_jal) begin
          rf_we        = 1'b1;
          w_waddr      = 5'd31;
          RF_writedata = r_pc;
        end
        instr_done = !(w_ralu || w_addi || w_lw || w_sw);
      end
      S_MEM: instr_done = w_sw && bus.mem_ready;
      S_WB: begin
        rf_we        = 1'b1;
        w_waddr      = w_rtype ? w_rd : w_rt;
        RF_writedata = w_lw ? r_mdr : r_alu;
        instr_done   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (rf_we && w_waddr != 5'd0) begin
      r_rf[w_waddr] <= RF_writedata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IF;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_alu   <= '0;
      r_mdr   <= '0;
      r_cen   <= 1'b1;
      r_wen   <= 1'b1;
    end else begin
      case (r_state)
        S_IF: begin
          r_ir    <= bus.IR;
          r_pc    <= r_pc + 32'd4;
          r_state <= S_ID;
        end
        S_ID: begin
          r_a     <= r_rf[w_rs];
          r_b     <= r_rf[w_rt];
          r_alu   <= r_pc + {w_simm[29:0], 2'b00};
          r_state <= S_EX;
        end
        S_EX: begin
          r_state <= S_IF;
          if (w_ralu) begin
            r_alu   <= w_alu_r;
            r_state <= S_WB;
          end else if (w_addi) begin
            r_alu   <= r_a + w_simm;
            r_state <= S_WB;
          end else if (w_lw || w_sw) begin
            r_alu   <= r_a + w_simm;
            r_state <= S_MEM;
            r_cen   <= 1'b0;
            r_wen   <= ~w_sw;
          end else if ((w_beq && r_a == r_b) || (w_bne && r_a != r_b)) begin
            r_pc <= r_alu;
          end else if (w_j || w_jal) begin
            r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
          end else if (w_jr) begin
            r_pc <= r_a;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            r_cen <= 1'b1;
            r_wen <= 1'b1;
            if (w_lw) begin
              r_mdr   <= bus.ReadDataMem;
              r_state <= S_WB;
            end else begin
              r_state <= S_IF;
            end
          end
        end
        S_WB:    r_state <= S_IF;
        default: r_state <= S_IF;
      endcase
    end
  end

  assign bus.IR_addr   = r_pc;
  assign bus.CEN       = r_cen;
  assign bus.WEN       = r_wen;
  assign bus.OEN       = 1'b0;
  assign bus.A         = r_alu[DMEM_AW+1:2];
  assign bus.ReadData2 = r_b;
  assign fsm_state     = r_state;
endmodule

// File: tb/tb_multicycle_mips.sv
// Bench for multicycle_mips: directed program then random instructions, each
// checked against an instruction-level reference model (result, latency, bus).
module tb_multicycle_mips;
  logic        clk;
  logic        rst_n;
  logic [31:0] RF_writedata;
  logic        rf_we;
  logic [2:0]  fsm_state;
  logic        instr_done;

  multicycle_mips_if #(.DMEM_AW(7)) bus ();

  multicycle_mips #(.DMEM_AW(7), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master),
    .RF_writedata(RF_writedata), .rf_we(rf_we),
    .fsm_state(fsm_state), .instr_done(instr_done)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int wait_n   = 0;
  int mem_cnt;

  logic [31:0] imem [1024];
  logic [31:0] sram [128];
  logic [31:0] m_rf [32];
  logic [31:0] m_mem [128];
  logic [31:0] m_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fetch(input logic [31:0] a);
    return (a < 32'h1000) ? imem[a[11:2]] : 32'h0;
  endfunction

  // Instruction ROM and wait-state data SRAM
  always @(negedge clk) bus.IR = fetch(bus.IR_addr);
  assign bus.ReadDataMem = sram[bus.A];
  assign bus.mem_ready   = (bus.CEN === 1'b0) && (mem_cnt >= wait_n);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mem_cnt <= 0;
    else if (bus.CEN === 1'b0 && !bus.mem_ready) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  always @(posedge clk)
    if (bus.CEN === 1'b0 && bus.WEN === 1'b0 && bus.mem_ready) sram[bus.A] <= bus.ReadData2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_j(input int op, input logic [25:0] tgt);
    return {6'(op), tgt};
  endfunction

  function automatic logic [31:0] rand_ins();
    int k = $urandom_range(0, 9);
    int rs = $urandom_range(0, 15);
    int rt = $urandom_range(0, 15);
    int rd = $urandom_range(0, 15);
    int fsel = $urandom_range(0, 5);
    int fn = (fsel == 0) ? 32 : (fsel == 1) ? 34 : (fsel == 2) ? 36 :
             (fsel == 3) ? 37 : (fsel == 4) ? 39 : 42;
    case (k)
      0, 1, 2: return enc_r(rs, rt, rd, fn);
      3:       return enc_i(8, rs, rt, 16'($urandom));
      4:       return enc_i(35, rs, rt, 16'($urandom_range(0, 16'h7FFF)));
      5:       return enc_i(43, rs, rt, 16'($urandom_range(0, 16'h7FFF)));
      6:       return enc_i(4, rs, ($urandom_range(0, 1) != 0) ? rs : rt, 16'($urandom_range(0, 3)));
      7:       return enc_i(5, rs, ($urandom_range(0, 1) != 0) ? rs : rt, 16'($urandom_range(0, 3)));
      8:       return ($urandom_range(0, 1) != 0) ? enc_i(63, rs, rt, 16'h1234) : enc_r(rs, rt, rd, 0);
      default: return enc_i(8, 0, rt, 16'($urandom));
    endcase
  endfunction

  // Run one instruction on the DUT and compare against ISA-level semantics.
  // Entered and left #1 after the rising edge that starts an IF cycle.
  task automatic exec_one(input int waits);
    logic [31:0] ins  = fetch(m_pc);
    logic [5:0]  op   = ins[31:26];
    logic [5:0]  fn   = ins[5:0];
    int          rs   = int'(ins[25:21]);
    int          rt   = int'(ins[20:16]);
    int          rd   = int'(ins[15:11]);
    logic [31:0] simm = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] va   = m_rf[rs];
    logic [31:0] vb   = m_rf[rt];
    logic [31:0] npc  = m_pc + 32'd4;
    logic [31:0] ea   = va + simm;
    logic [31:0] wd   = '0;
    int  dst = 0, ecyc = 3, nwe = 0, nmem = 0, cyc = 0;
    bit  we = 0, ismem = 0, isst = 0, done = 0;
    case (op)
      6'h00: begin
        we = 1; dst = rd; ecyc = 4;
        case (fn)
          6'h20: wd = va + vb;
          6'h22: wd = va - vb;
          6'h24: wd = va & vb;
          6'h25: wd = va | vb;
          6'h27: wd = ~(va | vb);
          6'h2A: wd = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          6'h08: begin we = 0; ecyc = 3; npc = va; end
          default: begin we = 0; ecyc = 3; end
        endcase
      end
      6'h08: begin we = 1; dst = rt; ecyc = 4; wd = va + simm; end
      6'h23: begin we = 1; dst = rt; ismem = 1; ecyc = 5 + waits; wd = m_mem[ea[8:2]]; end
      6'h2B: begin ismem = 1; isst = 1; ecyc = 4 + waits; end
      6'h04: if (va == vb) npc = npc + (simm << 2);
      6'h05: if (va != vb) npc = npc + (simm << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin we = 1; dst = 31; wd = npc; npc = {npc[31:28], ins[25:0], 2'b00}; end
      default: ;
    endcase
    wait_n = waits;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rf_we === 1'b1) begin
        nwe++;
        chk("rf_wdata", RF_writedata, wd);
      end
      if (bus.CEN === 1'b0) begin
        nmem++;
        chk("mem_addr", 32'(bus.A), 32'(ea[8:2]));
        chk("mem_wen", 32'(bus.WEN), isst ? 32'd0 : 32'd1);
        if (isst) chk("store_data", bus.ReadData2, vb);
      end
      done = (instr_done === 1'b1);
    end
    chk("instr_done_seen", 32'(done), 32'd1);
    chk("latency", 32'(cyc), 32'(ecyc));
    chk("rf_we_cycles", 32'(nwe), we ? 32'd1 : 32'd0);
    chk("cen_cycles", 32'(nmem), ismem ? 32'(waits + 1) : 32'd0);
    @(posedge clk); #1;
    chk("state_after", 32'(fsm_state), 32'd0);
    chk("next_pc", bus.IR_addr, npc);
    if (we && dst != 0) m_rf[dst] = wd;
    if (isst) m_mem[ea[8:2]] = vb;
    m_pc = npc;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    for (int i = 0; i < 128; i++) begin
      sram[i]  = $urandom;
      m_mem[i] = sram[i];
    end
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc = 32'h100;

    imem[32'h100 >> 2] = enc_i(8, 0, 1, 16'd5);
    imem[32'h104 >> 2] = enc_i(8, 0, 2, 16'hFFFD);
    imem[32'h108 >> 2] = enc_r(2, 1, 3, 42);
    imem[32'h10C >> 2] = enc_r(1, 2, 4, 39);
    imem[32'h110 >> 2] = enc_i(43, 0, 1, 16'd8);
    imem[32'h114 >> 2] = enc_i(35, 0, 5, 16'd8);
    imem[32'h118 >> 2] = enc_i(4, 1, 1, 16'd2);
    imem[32'h11C >> 2] = enc_i(8, 0, 1, 16'd99);
    imem[32'h120 >> 2] = enc_i(8, 0, 1, 16'd99);
    imem[32'h124 >> 2] = enc_i(5, 1, 1, 16'd2);
    imem[32'h128 >> 2] = enc_i(8, 0, 0, 16'd7);
    imem[32'h12C >> 2] = enc_r(0, 0, 6, 32);
    imem[32'h130 >> 2] = enc_j(2, 26'h4);
    imem[32'h010 >> 2] = enc_j(3, 26'h40);
    imem[32'h014 >> 2] = enc_j(2, 26'h80);
    for (int i = 0; i < 150; i++) imem[(32'h200 >> 2) + i] = rand_ins();

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ir_addr", bus.IR_addr, 32'h100);
    chk("rst_cen", 32'(bus.CEN), 32'd1);
    chk("rst_wen", 32'(bus.WEN), 32'd1);
    chk("rst_oen", 32'(bus.OEN), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_done", 32'(instr_done), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("first_fetch", bus.IR_addr, 32'h100);

    // addi, addi, slt, nor, sw (2 waits), lw, beq, bne, $0 write, add, j, jal
    for (int i = 0; i < 4; i++) exec_one(0);
    exec_one(2);
    exec_one(0);
    chk("lw_reg5", m_rf[5], 32'd5);
    imem[32'h100 >> 2] = enc_r(31, 0, 0, 8);
    for (int i = 0; i < 6; i++) exec_one(0);
    chk("jal_pc", m_pc, 32'h100);
    exec_one(0);
    chk("jr_pc", m_pc, 32'h14);
    exec_one(0);

    for (int i = 0; i < 150; i++) exec_one($urandom_range(0, 3));

    // Reset while a load is stalled in MEM
    imem[m_pc[11:2]] = enc_i(8, 0, 1, 16'h55);
    exec_one(0);
    imem[m_pc[11:2]] = enc_i(35, 0, 9, 16'h10);
    wait_n = 100;
    for (int k = 0; k < 20 && bus.CEN !== 1'b0; k++) @(negedge clk);
    chk("reach_mem", 32'(bus.CEN), 32'd0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cen", 32'(bus.CEN), 32'd1);
    chk("arst_wen", 32'(bus.WEN), 32'd1);
    chk("arst_state", 32'(fsm_state), 32'd0);
    chk("arst_pc", bus.IR_addr, 32'h100);
    chk("arst_rf_we", 32'(rf_we), 32'd0);
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc = 32'h100;
    imem[32'h100 >> 2] = enc_r(1, 9, 7, 32);
    wait_n = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    exec_one(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
